// File: rtl/thor2022_page_walker_if.sv
// Thor2022 page walker read-only bus interface.
// Walker drives cyc/adr, memory side returns ack/dat.
interface thor2022_page_walker_if;
  logic         cyc;
  logic [31:0]  adr;
  logic         ack;
  logic [127:0] dat;

  modport master (
    output cyc, adr,
    input  ack, dat
  );

  modport slave (
    input  cyc, adr,
    output ack, dat
  );
endinterface

// File: rtl/thor2022_page_walker.sv
// Thor2022 two-level hardware page-table walker feeding the TLB.
// Optional one-entry L1 cache: define THOR2022_PTW_L1CACHE_EN.
module thor2022_page_walker #(
  parameter int TLBEW   = 256,
  parameter int PTE_V   = 22,
  parameter int WAY     = 0,
  parameter int TMO     = 255,
  parameter int HOLDOFF = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             miss_i,
  input  logic [31:0]      miss_adr_i,
  input  logic [31:0]      ptbr_i,
  input  logic             flush_i,
  input  logic             tlb_rdy_i,
  thor2022_page_walker_if.master m,
  output logic             wrtlb_o,
  output logic [15:0]      tlbadr_o,
  output logic [TLBEW-1:0] tlbdat_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [1:0]       fault_cause_o,
  output logic [31:0]      fault_adr_o
);

  typedef enum logic [1:0] {
    IDLE, L1, L2, WRITE
  } state_t;

  state_t      st, st_n;
  logic [31:0] va;
  logic [19:0] l2base;
  logic [7:0]  tmo_cnt;
  logic [7:0]  hold;
  logic        cyc;
  logic        flt_c;
  logic [1:0]  cause_c;
  logic        start;
  logic        ack_ok;
  logic        tmo_hit;
  logic        hit;
  logic [19:0] hit_base;
  logic        unused_bits;

  assign start   = miss_i && (hold == 8'd0) && !flush_i;
  assign ack_ok  = cyc && m.ack;
  assign tmo_hit = cyc && !m.ack && (tmo_cnt == 8'(TMO - 1));
  assign m.cyc   = cyc;
  assign busy_o  = (st != IDLE);
  assign tlbadr_o = {va[26:16], 2'b00, 3'(WAY)};
  assign unused_bits = ^{ptbr_i[11:0], m.dat[127:96]};

`ifdef THOR2022_PTW_L1CACHE_EN
  logic        c_vld;
  logic [7:0]  c_tag;
  logic [19:0] c_ptbr;
  logic [19:0] c_base;

  assign hit = c_vld
            && (c_tag == miss_adr_i[31:24])
            && (c_ptbr == ptbr_i[31:12]);
  assign hit_base = c_base;

  // Remember the last valid L1 entry; flush drops it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_vld  <= 1'b0;
      c_tag  <= '0;
      c_ptbr <= '0;
      c_base <= '0;
    end else if (flush_i) begin
      c_vld <= 1'b0;
    end else if (st == L1 && st_n == L2) begin
      c_vld  <= 1'b1;
      c_tag  <= va[31:24];
      c_ptbr <= ptbr_i[31:12];
      c_base <= m.dat[31:12];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_base = '0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= IDLE;
    else         st <= st_n;
  end

  // Next state, bus address, TLB strobe and fault decode.
  always_comb begin
    st_n    = st;
    flt_c   = 1'b0;
    cause_c = 2'b00;
    wrtlb_o = 1'b0;
    m.adr   = '0;
    unique case (st)
      IDLE: begin
        if (start) st_n = hit ? L2 : L1;
      end
      L1: begin
        m.adr = {ptbr_i[31:12], va[31:24], 4'h0};
        if (flush_i) begin
          st_n = IDLE;
        end else if (ack_ok) begin
          if (!m.dat[PTE_V]) begin
            flt_c   = 1'b1;
            cause_c = 2'b01;
            st_n    = IDLE;
          end else begin
            st_n = L2;
          end
        end else if (tmo_hit) begin
          flt_c   = 1'b1;
          cause_c = 2'b11;
          st_n    = IDLE;
        end
      end
      L2: begin
        m.adr = {l2base, va[23:16], 4'h0};
        if (flush_i) begin
          st_n = IDLE;
        end else if (ack_ok) begin
          if (!m.dat[PTE_V]) begin
            flt_c   = 1'b1;
            cause_c = 2'b10;
            st_n    = IDLE;
          end else begin
            st_n = WRITE;
          end
        end else if (tmo_hit) begin
          flt_c   = 1'b1;
          cause_c = 2'b11;
          st_n    = IDLE;
        end
      end
      WRITE: begin
        if (flush_i) begin
          st_n = IDLE;
        end else if (tlb_rdy_i) begin
          wrtlb_o = 1'b1;
          st_n    = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Walk datapath: latches, bus cycle, timeout, hold-off, faults.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      va            <= '0;
      l2base        <= '0;
      tmo_cnt       <= '0;
      hold          <= '0;
      cyc           <= 1'b0;
      tlbdat_o      <= '0;
      fault_o       <= 1'b0;
      fault_cause_o <= 2'b00;
      fault_adr_o   <= '0;
    end else begin
      fault_o <= flt_c;
      if (flt_c) begin
        fault_cause_o <= cause_c;
        fault_adr_o   <= va;
      end
      if (cyc && !m.ack) tmo_cnt <= tmo_cnt + 8'd1;
      unique case (st)
        IDLE: begin
          if (hold != 8'd0) hold <= hold - 8'd1;
          if (start) begin
            va      <= miss_adr_i;
            tmo_cnt <= '0;
            cyc     <= !hit;
            if (hit) l2base <= hit_base;
          end
        end
        L1: begin
          if (st_n != L1) begin
            cyc     <= 1'b0;
            tmo_cnt <= '0;
          end
          if (st_n == L2) l2base <= m.dat[31:12];
        end
        L2: begin
          if (st_n != L2) cyc <= 1'b0;
          else if (!cyc)  cyc <= 1'b1;
          if (st_n == WRITE)
            tlbdat_o <= TLBEW'({m.adr, m.dat[95:0]});
        end
        WRITE: begin
          if (wrtlb_o) hold <= 8'(HOLDOFF);
        end
        default: cyc <= 1'b0;
      endcase
    end
  end

endmodule
